// File: rtl/poly_store_control_bram_pkg.sv
// Shared definitions for the polynomial load/store controllers: default geometry
// and the common controller state encoding.
package poly_store_control_bram_pkg;

  localparam int NUM_WORDS_DEF = 16;
  localparam int DATA_W_DEF    = 64;
  localparam int ADDR_W_DEF    = 8;
  localparam int SRC_AW_DEF    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } poly_state_e;

endpackage

// File: rtl/poly_store_control_bram_skid_fifo.sv
// Two-entry FIFO absorbing the accumulator's one-cycle read latency while the
// BRAM write port is stalled.
module poly_store_skid_fifo #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_r [2];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;

  // storage, pointers and occupancy; push+pop together leaves count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
      end
      wr_ptr_r <= wr_ptr_r ^ push;
      rd_ptr_r <= rd_ptr_r ^ pop;
      count_r  <= count_r + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/poly_store_control_bram.sv
// Streams a finished polynomial from the accumulator into a stallable BRAM
// write port, one word per cycle, preserving word order.
module poly_store_control_bram
  import poly_store_control_bram_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int SRC_AW    = SRC_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              src_rd_en,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  input  logic              bram_gnt,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              busy,
  output logic              poly_store_done
);

  localparam int CW = SRC_AW + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_WORDS);

  poly_state_e       state_r;
  poly_state_e       state_nxt_s;
  logic [CW-1:0]     rd_cnt_r;
  logic [CW-1:0]     wr_cnt_r;
  logic [ADDR_W-1:0] base_q_r;
  logic              inflight_r;

  logic [1:0]        fifo_count_s;
  logic [DATA_W-1:0] fifo_head_s;
  logic [2:0]        occ_s;
  logic              busy_s;
  logic              accept_s;
  logic              we_s;
  logic              rd_en_s;

  assign busy_s   = (state_r == ST_STORE) || (state_r == ST_DRAIN);
  assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign occ_s    = {1'b0, fifo_count_s} + {2'b00, inflight_r};
  assign we_s     = !rst && busy_s && bram_gnt && (fifo_count_s != 2'd0);
  // A read is only issued if its data is guaranteed a FIFO slot next cycle
  assign rd_en_s  = !rst && (state_r == ST_STORE) && (rd_cnt_r < LAST_CNT) &&
                    (occ_s < (3'd2 + {2'b00, we_s}));

  // next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_STORE;
        else       state_nxt_s = ST_IDLE;
      end
      ST_STORE: begin
        if (rd_cnt_r == LAST_CNT) state_nxt_s = ST_DRAIN;
        else                      state_nxt_s = ST_STORE;
      end
      ST_DRAIN: begin
        if (we_s && (wr_cnt_r == (LAST_CNT - CW'(1)))) state_nxt_s = ST_DONE;
        else                                           state_nxt_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (start) state_nxt_s = ST_STORE;
        else       state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // state, word counters, captured base and read-in-flight flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rd_cnt_r   <= '0;
      wr_cnt_r   <= '0;
      base_q_r   <= '0;
      inflight_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      inflight_r <= rd_en_s;
      if (accept_s) begin
        rd_cnt_r <= '0;
        wr_cnt_r <= '0;
        base_q_r <= base_addr;
      end else begin
        if (rd_en_s) rd_cnt_r <= rd_cnt_r + CW'(1);
        if (we_s)    wr_cnt_r <= wr_cnt_r + CW'(1);
      end
    end
  end

  poly_store_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_r),
    .pop   (we_s),
    .din   (src_data),
    .head  (fifo_head_s),
    .count (fifo_count_s)
  );

  assign src_rd_en       = rd_en_s;
  assign src_addr        = rd_cnt_r[SRC_AW-1:0];
  assign bram_we         = we_s;
  assign bram_addr       = base_q_r + ADDR_W'(wr_cnt_r);
  assign bram_din        = fifo_head_s;
  assign busy            = busy_s;
  assign poly_store_done = (state_r == ST_DONE);

endmodule

// File: tb/tb_poly_store_control_bram.sv
// Directed bench for poly_store_control_bram: table of store passes with a
// behavioural accumulator, plus hand-written reset sequences.
module tb_poly_store_control_bram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = 8'h00;
  logic        src_rd_en;
  logic [4:0]  src_addr;
  logic [63:0] src_data = 64'h0;
  logic        bram_gnt = 1'b0;
  logic        bram_we;
  logic [7:0]  bram_addr;
  logic [63:0] bram_din;
  logic        busy;
  logic        done;

  int nchk = 0;
  int nerr = 0;
  int pass_id = 0;

  typedef struct {
    logic [7:0] base;
    int         lo;
    int         hi;
    int         glitch;
    bit         rnd;
    int         exp_first;
    int         exp_done;
  } vec_t;

  vec_t vecs [6];

  poly_store_control_bram dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .base_addr       (base_addr),
    .src_rd_en       (src_rd_en),
    .src_addr        (src_addr),
    .src_data        (src_data),
    .bram_gnt        (bram_gnt),
    .bram_we         (bram_we),
    .bram_addr       (bram_addr),
    .bram_din        (bram_din),
    .busy            (busy),
    .poly_store_done (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word_of(input int p, input int k);
    logic [15:0] ps;
    logic [7:0]  ks;
    ps = p[15:0];
    ks = k[7:0];
    return {16'hC0DE, ps, 24'h000000, ks};
  endfunction

  // accumulator: data valid one cycle after a read strobe, garbage otherwise
  always @(posedge clk) begin
    src_data <= src_rd_en ? word_of(pass_id, int'(src_addr)) : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, 64'(src_rd_en), 64'd0);
    check({tag, "_src_addr"}, 64'(src_addr), 64'd0);
    check({tag, "_we"}, 64'(bram_we), 64'd0);
    check({tag, "_bram_addr"}, 64'(bram_addr), 64'd0);
    check({tag, "_din"}, bram_din, 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic run_pass(input vec_t v, input string tag);
    logic [7:0]  wa [$];
    logic [63:0] wd [$];
    int first_rel = -1;
    int done_rel = -1;
    int nrd = 0;
    int fifo_m = 0;
    int infl_m = 0;
    int max_fifo = 0;
    int bad_we = 0;
    int post_bad = 0;
    bit rd_prev = 1'b0;
    bit we_prev = 1'b0;
    bit fin = 1'b0;
    logic done_at1 = 1'b0;
    logic busy_at1 = 1'b0;
    pass_id++;
    for (int rel = 0; rel < 300 && !fin; rel++) begin
      @(negedge clk);
      start = (rel == 0) || (v.glitch > 0 && (rel == v.glitch || rel == v.glitch + 14));
      base_addr = (rel == 0) ? v.base : 8'hAA;
      if (v.rnd) bram_gnt = ($urandom_range(0, 1) == 1);
      else       bram_gnt = !(rel >= v.lo && rel <= v.hi);
      #1;
      fifo_m = fifo_m + infl_m - int'(we_prev);
      infl_m = int'(rd_prev);
      if (fifo_m > max_fifo) max_fifo = fifo_m;
      if (rel == 1) begin
        done_at1 = done;
        busy_at1 = busy;
      end
      if (src_rd_en) nrd++;
      if (bram_we) begin
        if (fifo_m == 0) bad_we++;
        wa.push_back(bram_addr);
        wd.push_back(bram_din);
        if (first_rel < 0) first_rel = rel;
      end
      rd_prev = src_rd_en;
      we_prev = bram_we;
      if (done_rel >= 0) begin
        if (bram_we || busy || src_rd_en || !done) post_bad++;
        if (rel >= done_rel + 3) fin = 1'b1;
      end else if (done && rel > 0) begin
        done_rel = rel;
      end
    end
    check({tag, "_done_seen"}, 64'(done_rel >= 0), 64'd1);
    if (v.exp_done >= 0)  check({tag, "_done_cycle"}, 64'(done_rel), 64'(v.exp_done));
    if (v.exp_first >= 0) check({tag, "_first_write"}, 64'(first_rel), 64'(v.exp_first));
    check({tag, "_nwrites"}, 64'(wa.size()), 64'd16);
    check({tag, "_nreads"}, 64'(nrd), 64'd16);
    check({tag, "_fifo_max_le2"}, 64'(max_fifo <= 2), 64'd1);
    check({tag, "_we_on_empty"}, 64'(bad_we), 64'd0);
    check({tag, "_after_done"}, 64'(post_bad), 64'd0);
    check({tag, "_done_low_c1"}, 64'(done_at1), 64'd0);
    check({tag, "_busy_c1"}, 64'(busy_at1), 64'd1);
    for (int k = 0; k < wa.size() && k < 16; k++) begin
      check($sformatf("%s_addr%0d", tag, k), 64'(wa[k]), 64'(8'(v.base + 8'(k))));
      check($sformatf("%s_data%0d", tag, k), wd[k], word_of(pass_id, k));
    end
  endtask

  task automatic reset_mid();
    pass_id++;
    for (int rel = 0; rel <= 10; rel++) begin
      @(negedge clk);
      start = (rel == 0);
      base_addr = 8'h33;
      bram_gnt = 1'b1;
      rst = (rel == 8);
      #1;
      if (rel == 7) check("rst_we_before", 64'(bram_we), 64'd1);
      if (rel == 8) check("rst_we_on_reset_cycle", 64'(bram_we), 64'd0);
      if (rel == 9) check_idle_outputs("rst_after");
      if (rel == 10) check("rst_stays_idle", 64'({busy, done, src_rd_en}), 64'd0);
    end
  endtask

  initial begin
    vecs[0] = '{base: 8'h20, lo: -1, hi: -1, glitch: 0, rnd: 1'b0, exp_first: 3,  exp_done: 19};
    vecs[1] = '{base: 8'h20, lo: 5,  hi: 9,  glitch: 0, rnd: 1'b0, exp_first: 3,  exp_done: 24};
    vecs[2] = '{base: 8'hF8, lo: -1, hi: -1, glitch: 0, rnd: 1'b0, exp_first: 3,  exp_done: 19};
    vecs[3] = '{base: 8'h40, lo: -1, hi: -1, glitch: 4, rnd: 1'b0, exp_first: 3,  exp_done: 19};
    vecs[4] = '{base: 8'h7E, lo: -1, hi: -1, glitch: 0, rnd: 1'b1, exp_first: -1, exp_done: -1};
    vecs[5] = '{base: 8'h00, lo: -1, hi: -1, glitch: 0, rnd: 1'b1, exp_first: -1, exp_done: -1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_idle_outputs("post_reset");

    for (int i = 0; i < 6; i++) begin
      run_pass(vecs[i], $sformatf("v%0d", i));
    end

    reset_mid();
    run_pass(vecs[0], "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
